// File: rtl/unified_memory_arbiter_if.sv
// Handshake bundle for the unified memory arbiter: fetch port, data port and memory port.
// slave = arbiter side, master = pipeline/memory side.
interface unified_memory_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Instruction-fetch port
  logic                  if_req_valid;
  logic [ADDR_WIDTH-1:0] if_req_addr;
  logic                  if_rsp_valid;
  logic [DATA_WIDTH-1:0] if_rsp_data;
  logic                  if_stall;

  // Data-memory port
  logic                  dm_req_valid;
  logic                  dm_req_we;
  logic [ADDR_WIDTH-1:0] dm_req_addr;
  logic [DATA_WIDTH-1:0] dm_req_wdata;
  logic [3:0]            dm_req_be;
  logic                  dm_rsp_valid;
  logic [DATA_WIDTH-1:0] dm_rsp_rdata;
  logic                  dm_stall;

  // Unified memory port
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic [3:0]            mem_req_be;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_rdata;

  logic                  bus_error;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_rsp_valid, if_rsp_data, if_stall,
    input  dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_req_be,
    output dm_rsp_valid, dm_rsp_rdata, dm_stall,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output bus_error
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_rsp_valid, if_rsp_data, if_stall,
    output dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_req_be,
    input  dm_rsp_valid, dm_rsp_rdata, dm_stall,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  bus_error
  );
endinterface

// File: rtl/unified_memory_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access, one transaction at a time.
// Define MEM_ARB_FAIRNESS_EN to bound consecutive data grants while a fetch is waiting.
module unified_memory_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int MAX_DATA_STREAK = 4
) (
  input logic                     clk,
  input logic                     reset,
  unified_memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP} state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  // Counter holds completed wait cycles, so it never needs to reach TIMEOUT_CYCLES itself.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  if (MAX_DATA_STREAK < 1) begin : g_bad_streak
    $error("MAX_DATA_STREAK must be at least 1");
  end

  state_t                state;
  owner_t                owner;
  logic [TW-1:0]         wait_cnt;
  logic                  req_valid_q;
  logic                  req_we_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;
  logic [3:0]            req_be_q;

  logic                  any_req;
  logic                  force_fetch;
  logic                  grant_data;
  logic                  rsp_hit;
  logic                  timeout_hit;
  logic                  done;
  logic [DATA_WIDTH-1:0] rsp_data;

  assign any_req = bus.if_req_valid | bus.dm_req_valid;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  logic [SW-1:0] streak;

  assign force_fetch = bus.if_req_valid && (streak >= SW'(MAX_DATA_STREAK));

  // Streak only means something while a fetch is actually waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else if (!bus.if_req_valid) begin
      streak <= '0;
    end else if (state == S_IDLE && any_req) begin
      streak <= grant_data ? streak + SW'(1) : '0;
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  // Data wins by default: the load/store belongs to an older instruction than the fetch.
  assign grant_data = bus.dm_req_valid && !force_fetch;

  // A real response on the last allowed cycle takes precedence over the timeout.
  assign rsp_hit     = (state == S_WAIT_RSP) && bus.mem_rsp_valid;
  assign timeout_hit = (state == S_WAIT_RSP) && !bus.mem_rsp_valid &&
                       (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign done        = rsp_hit || timeout_hit;
  assign rsp_data    = rsp_hit ? bus.mem_rsp_rdata : '0;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state       <= S_IDLE;
      owner       <= OWN_FETCH;
      wait_cnt    <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state       <= S_REQ;
            req_valid_q <= 1'b1;
            if (grant_data) begin
              owner       <= OWN_DATA;
              req_we_q    <= bus.dm_req_we;
              req_addr_q  <= bus.dm_req_addr;
              req_wdata_q <= bus.dm_req_wdata;
              req_be_q    <= bus.dm_req_be;
            end else begin
              owner       <= OWN_FETCH;
              req_we_q    <= 1'b0;
              req_addr_q  <= bus.if_req_addr;
              req_wdata_q <= '0;
              req_be_q    <= 4'b0000;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_req_ready) begin
            state       <= S_WAIT_RSP;
            req_valid_q <= 1'b0;
            wait_cnt    <= '0;
          end
        end
        S_WAIT_RSP: begin
          if (done) begin
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        default: begin
          state       <= S_IDLE;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_we    = req_we_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_wdata = req_wdata_q;
  assign bus.mem_req_be    = req_be_q;
  assign bus.bus_error     = timeout_hit;

  // Responses are routed combinationally so the stall drops in the same cycle the memory answers.
  always_comb begin
    // NOTE: defaults first so no branch leaves an output unassigned and infers a latch.
    bus.if_rsp_valid = 1'b0;
    bus.if_rsp_data  = '0;
    bus.dm_rsp_valid = 1'b0;
    bus.dm_rsp_rdata = '0;
    if (done) begin
      if (owner == OWN_DATA) begin
        bus.dm_rsp_valid = 1'b1;
        bus.dm_rsp_rdata = rsp_data;
      end else begin
        bus.if_rsp_valid = 1'b1;
        bus.if_rsp_data  = rsp_data;
      end
    end
  end

  assign bus.if_stall = bus.if_req_valid & ~bus.if_rsp_valid;
  assign bus.dm_stall = bus.dm_req_valid & ~bus.dm_rsp_valid;

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Randomised bench for unified_memory_arbiter: bench-side requesters and memory plus a transaction-level model.
module tb_unified_memory_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int MS = 4;
  localparam int NW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  unified_memory_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  unified_memory_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .MAX_DATA_STREAK(MS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Requesters
  bit          if_act, dm_act, dm_we;
  int          if_idx, dm_idx;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  // Reference model of the arbiter at transaction level
  bit          arb_free, req_phase, wait_phase, own_dm;
  int          wait_k;
  logic [31:0] exp_addr, exp_wdata;
  logic        exp_we;
  logic [3:0]  exp_be;
`ifdef MEM_ARB_FAIRNESS_EN
  int          streak;
`endif
  // Bench-side memory device
  bit          dev_busy, dev_we;
  int          dev_cnt, dev_lat;
  logic [3:0]  dev_idx, dev_be;
  logic [31:0] dev_wdata;
  logic [31:0] ref_mem [NW];
  logic [31:0] dev_mem [NW];
  // Stimulus knobs (percentages; lat_fixed 0 = random latency)
  int p_if, p_dm, p_ready, p_stray, lat_fixed;

  function automatic logic [31:0] word_addr(input int idx);
    return 32'h0000_1000 + 32'(idx) * 32'd4;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic model_init();
    arb_free = 1; req_phase = 0; wait_phase = 0; wait_k = 0;
    if_act = 0; dm_act = 0; dev_busy = 0;
`ifdef MEM_ARB_FAIRNESS_EN
    streak = 0;
`endif
  endtask

  task automatic drive_idle();
    bus.if_req_valid = 0; bus.if_req_addr = '0;
    bus.dm_req_valid = 0; bus.dm_req_we = 0; bus.dm_req_addr = '0;
    bus.dm_req_wdata = '0; bus.dm_req_be = '0;
    bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req_valid", bus.mem_req_valid, 0);
    check("rst_mem_req_we", bus.mem_req_we, 0);
    check("rst_mem_req_addr", bus.mem_req_addr, 0);
    check("rst_mem_req_wdata", bus.mem_req_wdata, 0);
    check("rst_mem_req_be", bus.mem_req_be, 0);
    check("rst_if_rsp_valid", bus.if_rsp_valid, 0);
    check("rst_dm_rsp_valid", bus.dm_rsp_valid, 0);
    check("rst_bus_error", bus.bus_error, 0);
    reset = 0;
    model_init();
  endtask

  // One clock cycle: check registered outputs, drive requesters and memory, check responses, advance model.
  task automatic step();
    logic        rdy, rsp;
    logic [31:0] rdat;
    bit          done, to, exp_if, exp_dm, v_if, g_dm, granted;
    int          r;
    @(posedge clk);
    #1;
    check("mem_req_valid", bus.mem_req_valid, req_phase);
    if (req_phase) begin
      check("mem_req_addr", bus.mem_req_addr, exp_addr);
      check("mem_req_we", bus.mem_req_we, exp_we);
      check("mem_req_be", bus.mem_req_be, exp_be);
      if (exp_we) check("mem_req_wdata", bus.mem_req_wdata, exp_wdata);
    end

    if (!if_act && $urandom_range(0, 99) < p_if) begin
      if_act = 1; if_idx = $urandom_range(0, NW - 1);
    end
    if (!dm_act && $urandom_range(0, 99) < p_dm) begin
      dm_act = 1; dm_we = 1'($urandom_range(0, 1)); dm_idx = $urandom_range(0, NW - 1);
      dm_wdata = $urandom; dm_be = 4'($urandom_range(1, 15));
    end
    bus.if_req_valid = if_act;  bus.if_req_addr = word_addr(if_idx);
    bus.dm_req_valid = dm_act;  bus.dm_req_we = dm_we;  bus.dm_req_addr = word_addr(dm_idx);
    bus.dm_req_wdata = dm_wdata; bus.dm_req_be = dm_be;

    rdy = 0; rsp = 0; rdat = $urandom;
    if (dev_busy) begin
      dev_cnt++;
      if (dev_cnt == dev_lat) begin
        rsp = 1; dev_busy = 0;
        if (dev_we) dev_mem[dev_idx] = merge(dev_mem[dev_idx], dev_wdata, dev_be);
        else rdat = dev_mem[dev_idx];
      end else if (dev_cnt >= TO) begin
        dev_busy = 0;  // arbiter has given up on this access
      end
    end else if (bus.mem_req_valid && $urandom_range(0, 99) < p_ready) begin
      rdy = 1; dev_busy = 1; dev_cnt = 0;
      dev_we = bus.mem_req_we; dev_idx = bus.mem_req_addr[5:2];
      dev_wdata = bus.mem_req_wdata; dev_be = bus.mem_req_be;
      if (lat_fixed != 0) dev_lat = lat_fixed;
      else begin
        r = $urandom_range(0, 99);
        dev_lat = (r < 8) ? 20 : (r < 14) ? TO : $urandom_range(1, 4);
      end
    end else if ($urandom_range(0, 99) < p_stray) begin
      rsp = 1;  // stray response, must be ignored
    end
    bus.mem_req_ready = rdy; bus.mem_rsp_valid = rsp; bus.mem_rsp_rdata = rdat;
    #1;

    done = 0; to = 0;
    if (wait_phase) begin
      wait_k++;
      if (rsp) done = 1;
      else if (wait_k == TO) begin done = 1; to = 1; end
    end
    exp_if = done && !own_dm;
    exp_dm = done && own_dm;
    check("if_rsp_valid", bus.if_rsp_valid, exp_if);
    check("dm_rsp_valid", bus.dm_rsp_valid, exp_dm);
    check("bus_error", bus.bus_error, to);
    check("if_stall", bus.if_stall, if_act && !exp_if);
    check("dm_stall", bus.dm_stall, dm_act && !exp_dm);
    if (exp_if) begin
      check("if_rsp_data", bus.if_rsp_data, to ? 32'd0 : ref_mem[if_idx]);
      check("dm_rdata_nonowner", bus.dm_rsp_rdata, 0);
    end
    if (exp_dm) begin
      if (to || !dm_we) check("dm_rsp_rdata", bus.dm_rsp_rdata, to ? 32'd0 : ref_mem[dm_idx]);
      check("if_data_nonowner", bus.if_rsp_data, 0);
    end

    v_if = if_act;
    granted = 0; g_dm = 0;
    if (done) begin
      wait_phase = 0; arb_free = 1;
      if (own_dm) begin
        if (!to && dm_we) ref_mem[dm_idx] = merge(ref_mem[dm_idx], dm_wdata, dm_be);
        dm_act = 0;
      end else begin
        if_act = 0;
      end
    end else if (req_phase && rdy) begin
      req_phase = 0; wait_phase = 1; wait_k = 0;
    end else if (arb_free && (if_act || dm_act)) begin
      g_dm = dm_act;
`ifdef MEM_ARB_FAIRNESS_EN
      if (if_act && streak >= MS) g_dm = 0;
`endif
      granted = 1; own_dm = g_dm; req_phase = 1; arb_free = 0;
      exp_addr  = g_dm ? word_addr(dm_idx) : word_addr(if_idx);
      exp_we    = g_dm && dm_we;
      exp_be    = g_dm ? dm_be : 4'b0000;
      exp_wdata = dm_wdata;
    end
`ifdef MEM_ARB_FAIRNESS_EN
    if (!v_if) streak = 0;
    else if (granted) streak = g_dm ? streak + 1 : 0;
`else
    if (granted && v_if && g_dm) checks = checks + 0;
`endif
  endtask

  task automatic run(input int n, input int pi, input int pd, input int pr, input int lf);
    p_if = pi; p_dm = pd; p_ready = pr; lat_fixed = lf;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    p_stray = 5;
    for (int i = 0; i < NW; i++) begin
      ref_mem[i] = $urandom;
      dev_mem[i] = ref_mem[i];
    end
    ref_mem[0] = 32'h00A0_0093;
    dev_mem[0] = 32'h00A0_0093;
    do_reset();

    run(30, 100, 0, 100, 1);     // fetch only, memory ready at once, answers next cycle
    run(2000, 45, 50, 60, 0);    // mixed traffic, random latency, stray responses
    run(300, 100, 100, 70, 0);   // both ports always requesting
    run(120, 50, 50, 100, 20);   // memory never answers: every access times out

    // Reset while waiting for a response, then a late response must be ignored.
    p_if = 100; p_dm = 0; p_ready = 100; lat_fixed = 20;
    for (int i = 0; i < 40 && !wait_phase; i++) step();
    check("reach_wait_rsp", wait_phase, 1);
    step();
    reset = 1;
    drive_idle();
    @(posedge clk);
    #1;
    reset = 0;
    bus.mem_rsp_valid = 1;
    bus.mem_rsp_rdata = 32'hDEAD_BEEF;
    #1;
    check("late_if_rsp_valid", bus.if_rsp_valid, 0);
    check("late_dm_rsp_valid", bus.dm_rsp_valid, 0);
    check("late_bus_error", bus.bus_error, 0);
    check("late_mem_req_valid", bus.mem_req_valid, 0);
    model_init();

    run(400, 45, 50, 60, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
